// File: rtl/rf_alu_pkg.sv
// Shared encodings for the RF_ALU command sequencer.
// The ALU_control values are the same ones the RF_ALU datapath decodes.
package rf_alu_pkg;

  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_SET   = 7'b0000000;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SLT     = 3'b010;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam int unsigned OPC_LSB = 0;
  localparam int unsigned OPC_MSB = 6;
  localparam int unsigned RD_LSB  = 7;
  localparam int unsigned RD_MSB  = 11;
  localparam int unsigned F3_LSB  = 12;
  localparam int unsigned F3_MSB  = 14;
  localparam int unsigned RS1_LSB = 15;
  localparam int unsigned RS1_MSB = 19;
  localparam int unsigned RS2_LSB = 20;
  localparam int unsigned RS2_MSB = 24;
  localparam int unsigned F7_LSB  = 25;
  localparam int unsigned F7_MSB  = 31;

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StExec,
    StWb,
    StSet,
    StResp
  } state_e;

endpackage

// File: rtl/rf_alu_decode.sv
// Combinational (funct7, funct3) to ALU_control decode with an illegal flag.
module rf_alu_decode
  import rf_alu_pkg::*;
(
  input  logic [6:0] funct7,
  input  logic [2:0] funct3,
  output logic [3:0] alu_ctrl,
  output logic       illegal
);

  always_comb begin
    alu_ctrl = ALU_AND;
    illegal  = 1'b0;
    case ({funct7, funct3})
      {F7_BASE, F3_ADD_SUB}: alu_ctrl = ALU_ADD;
      {F7_ALT,  F3_ADD_SUB}: alu_ctrl = ALU_SUB;
      {F7_BASE, F3_AND}:     alu_ctrl = ALU_AND;
      {F7_BASE, F3_OR}:      alu_ctrl = ALU_OR;
      {F7_BASE, F3_XOR}:     alu_ctrl = ALU_XOR;
      {F7_BASE, F3_SLT}:     alu_ctrl = ALU_SLT;
      default:               illegal  = 1'b1;
    endcase
  end

endmodule

// File: rtl/rf_alu_ctrl.sv
// Command sequencer driving the RF_ALU datapath: accepts one instruction, steps
// READ/EXEC/WB (or SET), then holds a response until it is accepted.
module rf_alu_ctrl
  import rf_alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_instr,
  input  logic [31:0] cmd_data,
  output logic [31:0] instr,
  output logic [3:0]  ALU_control,
  output logic        RegSet,
  output logic        RegWrite,
  output logic [31:0] Writedata,
  input  logic [31:0] ALU_result,
  input  logic        Zero,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_result,
  output logic        resp_zero,
  output logic        resp_err
);

  state_e      state_q, state_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] data_q, data_d;
  logic [3:0]  alu_q, alu_d;
  logic [31:0] result_d;
  logic        zero_d, err_d;
  logic [3:0]  dec_ctrl;
  logic        dec_illegal;
  logic [6:0]  opcode;
  logic [4:0]  rd_d;
  logic        drive_alu, drive_set;

  assign opcode = cmd_instr[OPC_MSB:OPC_LSB];

  rf_alu_decode u_decode (
    .funct7   (cmd_instr[F7_MSB:F7_LSB]),
    .funct3   (cmd_instr[F3_MSB:F3_LSB]),
    .alu_ctrl (dec_ctrl),
    .illegal  (dec_illegal)
  );

  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    data_d   = data_q;
    alu_d    = alu_q;
    result_d = resp_result;
    zero_d   = resp_zero;
    err_d    = resp_err;
    case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          ir_d     = cmd_instr;
          data_d   = cmd_data;
          alu_d    = dec_ctrl;
          zero_d   = 1'b0;
          err_d    = 1'b0;
          result_d = '0;
          if (opcode == OP_RTYPE && !dec_illegal) begin
            state_d = StRead;
          end else if (opcode == OP_SET) begin
            state_d  = StSet;
            result_d = cmd_data;
          end else begin
            // Illegal commands use the SET slot with nothing driven, giving
            // the same one-cycle turnaround as a register set.
            state_d = StSet;
            err_d   = 1'b1;
          end
        end
      end
      StRead: state_d = StExec;
      StExec: begin
        result_d = ALU_result;
        zero_d   = Zero;
        state_d  = StWb;
      end
      StWb:   state_d = StResp;
      StSet:  state_d = StResp;
      StResp: if (resp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign rd_d      = ir_d[RD_MSB:RD_LSB];
  assign drive_alu = (state_d == StRead) || (state_d == StExec) || (state_d == StWb);
  assign drive_set = (state_d == StSet) && !err_d;

  // Outputs are registered from next-state so they line up with the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      ir_q        <= '0;
      data_q      <= '0;
      alu_q       <= '0;
      cmd_ready   <= 1'b1;
      instr       <= '0;
      ALU_control <= '0;
      RegSet      <= 1'b0;
      RegWrite    <= 1'b0;
      Writedata   <= '0;
      resp_valid  <= 1'b0;
      resp_result <= '0;
      resp_zero   <= 1'b0;
      resp_err    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ir_q        <= ir_d;
      data_q      <= data_d;
      alu_q       <= alu_d;
      cmd_ready   <= (state_d == StIdle);
      instr       <= drive_alu ? ir_d : (drive_set ? {20'b0, rd_d, 7'b0} : '0);
      ALU_control <= drive_alu ? alu_d : '0;
      RegSet      <= drive_set && (rd_d != 5'd0);
      RegWrite    <= (state_d == StWb) && (rd_d != 5'd0);
      Writedata   <= drive_set ? data_d : '0;
      resp_valid  <= (state_d == StResp);
      resp_result <= result_d;
      resp_zero   <= zero_d;
      resp_err    <= err_d;
    end
  end

endmodule

// File: tb/tb_rf_alu_ctrl.sv
// Directed bench for rf_alu_ctrl with a small register-file/ALU model on the
// datapath side.
module tb_rf_alu_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_instr = '0;
  logic [31:0] cmd_data = '0;
  logic [31:0] instr;
  logic [3:0]  ALU_control;
  logic        RegSet, RegWrite;
  logic [31:0] Writedata;
  logic [31:0] ALU_result;
  logic        Zero;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_result;
  logic        resp_zero, resp_err;

  int vectors = 0;
  int errors  = 0;
  int wr_cnt  = 0;
  int set_cnt = 0;

  logic [31:0] rf [32] = '{default: 32'h0};
  logic [31:0] rs1_v, rs2_v, alu_y;

  always #5 clk = ~clk;

  rf_alu_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_instr   (cmd_instr),
    .cmd_data    (cmd_data),
    .instr       (instr),
    .ALU_control (ALU_control),
    .RegSet      (RegSet),
    .RegWrite    (RegWrite),
    .Writedata   (Writedata),
    .ALU_result  (ALU_result),
    .Zero        (Zero),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_result (resp_result),
    .resp_zero   (resp_zero),
    .resp_err    (resp_err)
  );

  // Register file and ALU standing in for RF_ALU.
  always_comb begin
    rs1_v = rf[instr[19:15]];
    rs2_v = rf[instr[24:20]];
    case (ALU_control)
      4'b0010: alu_y = rs1_v + rs2_v;
      4'b0110: alu_y = rs1_v - rs2_v;
      4'b0000: alu_y = rs1_v & rs2_v;
      4'b0001: alu_y = rs1_v | rs2_v;
      4'b0011: alu_y = rs1_v ^ rs2_v;
      4'b0111: alu_y = {31'b0, $signed(rs1_v) < $signed(rs2_v)};
      default: alu_y = 32'h0;
    endcase
  end
  assign ALU_result = alu_y;
  assign Zero       = (alu_y == 32'h0);

  always @(posedge clk) begin
    if (RegWrite && instr[11:7] != 5'd0) rf[instr[11:7]] <= ALU_result;
    if (RegSet && instr[11:7] != 5'd0) rf[instr[11:7]] <= Writedata;
    if (RegWrite) wr_cnt <= wr_cnt + 1;
    if (RegSet) set_cnt <= set_cnt + 1;
  end

  task automatic send(input logic [31:0] i, input logic [31:0] d);
    @(negedge clk);
    cmd_instr = i;
    cmd_data  = d;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic release_resp();
    @(negedge clk);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    vectors++;
    if ({cmd_ready, instr, ALU_control, Writedata, RegSet, RegWrite, resp_valid, resp_result,
         resp_zero, resp_err} !== {1'b1, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0})
    begin
      errors++;
      $display("FAIL reset_values got rdy=%0b instr=%h ctl=%h wd=%h set=%0b wr=%0b rv=%0b res=%h z=%0b e=%0b want rdy=1 rest 0",
               cmd_ready, instr, ALU_control, Writedata, RegSet, RegWrite, resp_valid,
               resp_result, resp_zero, resp_err);
    end
    rst = 1'b0;
  endtask

  task automatic test_set();
    logic [31:0] ins [2] = '{32'h00000080, 32'h00000100};
    logic [31:0] dat [2] = '{32'h0003eeee, 32'h00001111};
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (cmd_ready !== 1'b1) begin
        errors++;
        $display("FAIL set%0d_ready got %0b want 1", k, cmd_ready);
      end
      send(ins[k], dat[k]);
      vectors++;
      if ({RegSet, instr, Writedata, resp_valid, cmd_ready} !== {1'b1, ins[k], dat[k], 2'b00}) begin
        errors++;
        $display("FAIL set%0d_drive got set=%0b instr=%h wd=%h rv=%0b rdy=%0b want 1 %h %h 0 0",
                 k, RegSet, instr, Writedata, resp_valid, cmd_ready, ins[k], dat[k]);
      end
      @(negedge clk);
      vectors++;
      if ({RegSet, instr, Writedata, resp_valid, resp_result, resp_zero, resp_err} !==
          {1'b0, 32'h0, 32'h0, 1'b1, dat[k], 2'b00}) begin
        errors++;
        $display("FAIL set%0d_resp got set=%0b instr=%h wd=%h rv=%0b res=%h z=%0b e=%0b want 0 0 0 1 %h 0 0",
                 k, RegSet, instr, Writedata, resp_valid, resp_result, resp_zero, resp_err, dat[k]);
      end
      release_resp();
      vectors++;
      if ({resp_valid, cmd_ready} !== 2'b01) begin
        errors++;
        $display("FAIL set%0d_release got rv=%0b rdy=%0b want 0 1", k, resp_valid, cmd_ready);
      end
    end
    vectors++;
    if (rf[1] !== 32'h0003eeee || rf[2] !== 32'h00001111) begin
      errors++;
      $display("FAIL set_rf got x1=%h x2=%h want 0003eeee 00001111", rf[1], rf[2]);
    end
  endtask

  task automatic test_add();
    int w0 = wr_cnt;
    send(32'h00208533, 32'h0);
    vectors++;
    if ({instr, ALU_control, RegWrite, resp_valid} !== {32'h00208533, 4'b0010, 2'b00}) begin
      errors++;
      $display("FAIL add_read got instr=%h ctl=%b wr=%0b rv=%0b want 00208533 0010 0 0",
               instr, ALU_control, RegWrite, resp_valid);
    end
    @(negedge clk);
    vectors++;
    if ({RegWrite, resp_valid, cmd_ready, ALU_control} !== {3'b000, 4'b0010}) begin
      errors++;
      $display("FAIL add_exec got wr=%0b rv=%0b rdy=%0b ctl=%b want 0 0 0 0010",
               RegWrite, resp_valid, cmd_ready, ALU_control);
    end
    @(negedge clk);
    vectors++;
    if ({RegWrite, resp_valid} !== 2'b10) begin
      errors++;
      $display("FAIL add_wb got wr=%0b rv=%0b want 1 0", RegWrite, resp_valid);
    end
    @(negedge clk);
    vectors++;
    if ({RegWrite, resp_valid, resp_result, resp_zero, resp_err, instr, ALU_control} !==
        {1'b0, 1'b1, 32'h0003ffff, 2'b00, 32'h0, 4'h0}) begin
      errors++;
      $display("FAIL add_resp got wr=%0b rv=%0b res=%h z=%0b e=%0b instr=%h ctl=%h want 0 1 0003ffff 0 0 0 0",
               RegWrite, resp_valid, resp_result, resp_zero, resp_err, instr, ALU_control);
    end
    vectors++;
    if (wr_cnt - w0 !== 1 || rf[10] !== 32'h0003ffff) begin
      errors++;
      $display("FAIL add_write got pulses=%0d x10=%h want 1 0003ffff", wr_cnt - w0, rf[10]);
    end
    release_resp();
  endtask

  task automatic test_sub();
    send(32'h40108633, 32'h0);
    vectors++;
    if (ALU_control !== 4'b0110) begin
      errors++;
      $display("FAIL sub_ctl got %b want 0110", ALU_control);
    end
    repeat (3) @(negedge clk);
    vectors++;
    if ({resp_valid, resp_result, resp_zero, resp_err} !== {1'b1, 32'h0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL sub_resp got rv=%0b res=%h z=%0b e=%0b want 1 0 1 0",
               resp_valid, resp_result, resp_zero, resp_err);
    end
    release_resp();
  endtask

  task automatic test_illegal();
    logic [31:0] ins [2] = '{32'h400072b3, 32'h000002ff};
    for (int k = 0; k < 2; k++) begin
      int w0 = wr_cnt;
      int s0 = set_cnt;
      send(ins[k], 32'hdeadbeef);
      vectors++;
      if ({resp_valid, RegSet, RegWrite, instr, Writedata, cmd_ready} !== {3'b000, 64'h0, 1'b0})
      begin
        errors++;
        $display("FAIL ill%0d_t0 got rv=%0b set=%0b wr=%0b instr=%h wd=%h rdy=%0b want all 0",
                 k, resp_valid, RegSet, RegWrite, instr, Writedata, cmd_ready);
      end
      @(negedge clk);
      vectors++;
      if ({resp_valid, resp_err, resp_zero, resp_result} !== {1'b1, 1'b1, 1'b0, 32'h0}) begin
        errors++;
        $display("FAIL ill%0d_resp got rv=%0b e=%0b z=%0b res=%h want 1 1 0 0",
                 k, resp_valid, resp_err, resp_zero, resp_result);
      end
      release_resp();
      vectors++;
      if (wr_cnt != w0 || set_cnt != s0) begin
        errors++;
        $display("FAIL ill%0d_nowrite got wr=%0d set=%0d want 0 0", k, wr_cnt - w0, set_cnt - s0);
      end
    end
  endtask

  task automatic test_stall();
    int w0 = wr_cnt;
    int s0 = set_cnt;
    send(32'h00208033, 32'h0);
    for (int c = 0; c < 3; c++) begin
      vectors++;
      if ({cmd_ready, RegWrite, resp_valid} !== 3'b000) begin
        errors++;
        $display("FAIL stall_pipe%0d got rdy=%0b wr=%0b rv=%0b want 0 0 0",
                 c, cmd_ready, RegWrite, resp_valid);
      end
      @(negedge clk);
    end
    // A SET offered while busy must be ignored.
    cmd_instr = 32'h00000180;
    cmd_data  = 32'h0badf00d;
    cmd_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      vectors++;
      if ({resp_valid, resp_result, resp_zero, resp_err, cmd_ready} !==
          {1'b1, 32'h0003ffff, 3'b000}) begin
        errors++;
        $display("FAIL stall_hold%0d got rv=%0b res=%h z=%0b e=%0b rdy=%0b want 1 0003ffff 0 0 0",
                 c, resp_valid, resp_result, resp_zero, resp_err, cmd_ready);
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    release_resp();
    repeat (2) @(negedge clk);
    vectors++;
    if (wr_cnt != w0 || set_cnt != s0 || rf[3] !== 32'h0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_effects got wr=%0d set=%0d x3=%h rdy=%0b want 0 0 0 1",
               wr_cnt - w0, set_cnt - s0, rf[3], cmd_ready);
    end
  endtask

  task automatic test_reset_mid();
    int w0 = wr_cnt;
    send(32'h002085b3, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    vectors++;
    if ({cmd_ready, instr, ALU_control, Writedata, RegSet, RegWrite, resp_valid, resp_result,
         resp_zero, resp_err} !== {1'b1, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0})
    begin
      errors++;
      $display("FAIL rst_mid got rdy=%0b instr=%h ctl=%h wd=%h set=%0b wr=%0b rv=%0b res=%h want rdy=1 rest 0",
               cmd_ready, instr, ALU_control, Writedata, RegSet, RegWrite, resp_valid, resp_result);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (wr_cnt != w0 || rf[11] !== 32'h0 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_dropped got wr=%0d x11=%h rv=%0b want 0 0 0", wr_cnt - w0, rf[11], resp_valid);
    end
    send(32'h00000180, 32'h12345678);
    vectors++;
    if ({RegSet, instr, Writedata} !== {1'b1, 32'h00000180, 32'h12345678}) begin
      errors++;
      $display("FAIL rst_next_set got set=%0b instr=%h wd=%h want 1 00000180 12345678",
               RegSet, instr, Writedata);
    end
    @(negedge clk);
    vectors++;
    if ({resp_valid, resp_result} !== {1'b1, 32'h12345678}) begin
      errors++;
      $display("FAIL rst_next_resp got rv=%0b res=%h want 1 12345678", resp_valid, resp_result);
    end
    release_resp();
    vectors++;
    if (rf[3] !== 32'h12345678) begin
      errors++;
      $display("FAIL rst_next_rf got x3=%h want 12345678", rf[3]);
    end
  endtask

  initial begin
    test_reset();
    test_set();
    test_add();
    test_sub();
    test_illegal();
    test_stall();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
